// File: rtl/fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sequencer
// Description : Issue/stall sequencer that holds the PC while the shared
//               iterative FPU runs for its class latency, then issues one
//               FP register write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_sequencer #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 8,
  parameter int LAT_MISC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fpu_en,
  input  logic [4:0]  func5,
  input  logic [4:0]  rd,
  input  logic        reg_write_f,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic        wb_en_f,
  output logic [4:0]  wb_rd,
  output logic [15:0] retired
);

  // Counter is preloaded with latency-1 so that it spans exactly L EXEC cycles.
  localparam logic [3:0] c_ADD_M1  = 4'(LAT_ADD - 1);
  localparam logic [3:0] c_MUL_M1  = 4'(LAT_MUL - 1);
  localparam logic [3:0] c_DIV_M1  = 4'(LAT_DIV - 1);
  localparam logic [3:0] c_MISC_M1 = 4'(LAT_MISC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt, w_lat_m1;
  logic        r_fpu_start;
  logic [4:0]  r_fpu_op, r_wb_rd;
  logic        r_reg_write;
  logic [15:0] r_retired;
  logic        w_issue;

  always_comb begin
    case (func5)
      5'b00000, 5'b00001: w_lat_m1 = c_ADD_M1;
      5'b00010:           w_lat_m1 = c_MUL_M1;
      5'b00011:           w_lat_m1 = c_DIV_M1;
      default:            w_lat_m1 = c_MISC_M1;
    endcase
  end

  assign w_issue = (r_state == S_IDLE) & fpu_en & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = w_lat_m1;
        end
      end
      S_EXEC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_WB;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_WB:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_fpu_start <= 1'b0;
      r_fpu_op    <= 5'd0;
      r_wb_rd     <= 5'd0;
      r_reg_write <= 1'b0;
      r_retired   <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fpu_start <= w_issue;
      if (w_issue) begin
        r_fpu_op    <= func5;
        r_wb_rd     <= rd;
        r_reg_write <= reg_write_f;
      end
      if ((r_state == S_WB) && !flush) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  // Flush wins over an in-flight EXEC so the redirected fetch is not held.
  assign stall     = ~flush & (w_issue | (r_state == S_EXEC));
  assign busy      = (r_state != S_IDLE);
  assign fpu_start = r_fpu_start;
  assign fpu_op    = r_fpu_op;
  assign wb_rd     = r_wb_rd;
  assign wb_en_f   = (r_state == S_WB) & r_reg_write & ~flush;
  assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_fpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_sequencer
// Description : Scoreboard bench for fpu_sequencer; issued ops are queued with
//               their expected write-back and popped when the WB cycle shows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fpu_en;
  logic [4:0]  func5;
  logic [4:0]  rd;
  logic        reg_write_f;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        fpu_start;
  logic [4:0]  fpu_op;
  logic        wb_en_f;
  logic [4:0]  wb_rd;
  logic [15:0] retired;

  fpu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fpu_en      (fpu_en),
    .func5       (func5),
    .rd          (rd),
    .reg_write_f (reg_write_f),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .fpu_start   (fpu_start),
    .fpu_op      (fpu_op),
    .wb_en_f     (wb_en_f),
    .wb_rd       (wb_rd),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic [4:0] rd;
    logic       w;
    int         lat;
    int         ci;
  } exp_t;

  exp_t        sb_q[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  logic [15:0] exp_ret = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [4:0] f);
    case (f)
      5'b00000, 5'b00001: return 2;
      5'b00010:           return 3;
      5'b00011:           return 8;
      default:            return 1;
    endcase
  endfunction

  // WB is the only state that is busy without holding the PC.
  always @(negedge clk) begin
    if (rst_n && busy && !stall && !flush) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_en_f", {31'd0, wb_en_f}, {31'd0, e.w});
        chk("wb_rd",   {27'd0, wb_rd},   {27'd0, e.rd});
        chk("fpu_op",  {27'd0, fpu_op},  {27'd0, e.op});
        chk("wb_cycle", cyc - e.ci, e.lat + 1);
        chk("retired_pre", {16'd0, retired}, {16'd0, exp_ret});
        exp_ret = exp_ret + 16'd1;
      end
    end
  end

  // Enter right after a rising edge; leaves right after the edge ending the op.
  task automatic do_op(input logic [4:0] f, input logic [4:0] d, input logic w, input int flush_at);
    int L, nk;
    exp_t e;
    L = lat_of(f);
    nk = (flush_at != 0) ? flush_at + 1 : L + 2;
    fpu_en = 1'b1; func5 = f; rd = d; reg_write_f = w; flush = 1'b0;
    if (flush_at == 0) begin
      e.op = f; e.rd = d; e.w = w; e.lat = L; e.ci = cyc;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= nk; k++) begin
      flush = (flush_at != 0) && (k == flush_at + 1);
      @(negedge clk);
      chk("stall",     {31'd0, stall},     (!flush && k <= L + 1) ? 32'd1 : 32'd0);
      chk("fpu_start", {31'd0, fpu_start}, (k == 2) ? 32'd1 : 32'd0);
      chk("busy",      {31'd0, busy},      (k > 1) ? 32'd1 : 32'd0);
      if (flush) chk("wb_en_flush", {31'd0, wb_en_f}, 32'd0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    fpu_en = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_stall", {31'd0, stall},   32'd0);
      chk("idle_busy",  {31'd0, busy},    32'd0);
      chk("idle_wb",    {31'd0, wb_en_f}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fpu_en = 1'b1; func5 = 5'b00000; rd = 5'd7; reg_write_f = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    {31'd0, busy},      32'd0);
    chk("rst_start",   {31'd0, fpu_start}, 32'd0);
    chk("rst_retired", {16'd0, retired},   32'd0);
    chk("rst_op",      {27'd0, fpu_op},    32'd0);
    chk("rst_rd",      {27'd0, wb_rd},     32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fadd issues on the first edge after reset release
    do_op(5'b00000, 5'd7, 1'b1, 0);
    idle(1);
    chk("fadd_retired", {16'd0, retired}, 32'd1);

    // fdiv then fmul back-to-back
    do_op(5'b00011, 5'd3, 1'b1, 0);
    do_op(5'b00010, 5'd12, 1'b1, 0);
    idle(2);
    chk("b2b_retired", {16'd0, retired}, 32'd3);
    chk("hold_op",     {27'd0, fpu_op},  32'h02);
    chk("hold_rd",     {27'd0, wb_rd},   32'd12);

    // fdiv flushed in its 4th EXEC cycle
    do_op(5'b00011, 5'd9, 1'b1, 4);
    idle(2);
    chk("flush_retired", {16'd0, retired}, 32'd3);

    // compare with no FP write, then fsub and an unlisted code back-to-back
    do_op(5'b10100, 5'd5, 1'b0, 0);
    do_op(5'b00001, 5'd31, 1'b1, 0);
    do_op(5'b11111, 5'd0, 1'b1, 0);
    idle(1);
    chk("mix_retired", {16'd0, retired}, 32'd6);

    // asynchronous reset in the middle of an fdiv
    fpu_en = 1'b1; func5 = 5'b00011; rd = 5'd4; reg_write_f = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("arst_busy",    {31'd0, busy},    32'd0);
    chk("arst_retired", {16'd0, retired}, 32'd0);
    chk("arst_wb",      {31'd0, wb_en_f}, 32'd0);
    exp_ret = 16'd0;
    fpu_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // preset the counter to its top value, then one more op wraps it
    force dut.r_retired = 16'hffff;
    @(posedge clk); #1;
    release dut.r_retired;
    exp_ret = 16'hffff;
    do_op(5'b00100, 5'd1, 1'b1, 0);
    idle(1);
    chk("wrap_retired", {16'd0, retired}, 32'd0);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
